// File: rtl/gsim_ctrl.sv
// Gauss-Seidel solver sequencer: loads the b vector, issues one row update at a
// time in ascending order for N_ITER sweeps, then streams the x vector out.
module gsim_ctrl #(
  parameter int N      = 16,
  parameter int N_ITER = 40,
  parameter int AW     = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_en,
  output logic          b_wr,
  output logic [AW-1:0] b_addr,
  output logic          upd_req,
  output logic [AW-1:0] row,
  input  logic          upd_ack,
  output logic          x_rd,
  output logic [AW-1:0] x_addr,
  output logic          out_valid,
  output logic          busy
);

  localparam int SW = $clog2(N_ITER + 1);

  typedef enum logic [2:0] {IDLE, LOAD, ITER, WAIT, OUT} state_t;

  state_t        state_reg;
  logic          run_reg;
  logic [AW-1:0] load_cnt_reg;
  logic [AW-1:0] row_reg;
  logic [AW-1:0] x_cnt_reg;
  logic [SW-1:0] sweep_reg;
  logic [SW-1:0] sweep_inc;
  logic          out_valid_reg;

  // Reset is released into the logic one edge after deassertion, so the first
  // beat can only be taken on the second rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_reg <= 1'b0;
    else        run_reg <= 1'b1;
  end

  assign sweep_inc = sweep_reg + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      load_cnt_reg  <= '0;
      row_reg       <= '0;
      x_cnt_reg     <= '0;
      sweep_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= (state_reg == OUT);
      case (state_reg)
        IDLE: begin
          if (run_reg && in_en) begin
            load_cnt_reg <= AW'(1);
            state_reg    <= LOAD;
          end
        end
        LOAD: begin
          if (in_en) begin
            if (load_cnt_reg == AW'(N - 1)) begin
              load_cnt_reg <= '0;
              row_reg      <= '0;
              sweep_reg    <= '0;
              state_reg    <= ITER;
            end else begin
              load_cnt_reg <= load_cnt_reg + 1'b1;
            end
          end
        end
        ITER: state_reg <= WAIT;
        WAIT: begin
          if (upd_ack) begin
            if (row_reg == AW'(N - 1)) begin
              row_reg   <= '0;
              sweep_reg <= sweep_inc;
              // Compare with >= so the counter can never run past N_ITER.
              if (sweep_inc >= SW'(N_ITER)) begin
                x_cnt_reg <= '0;
                state_reg <= OUT;
              end else begin
                state_reg <= ITER;
              end
            end else begin
              row_reg   <= row_reg + 1'b1;
              state_reg <= ITER;
            end
          end
        end
        OUT: begin
          if (x_cnt_reg == AW'(N - 1)) begin
            x_cnt_reg <= '0;
            state_reg <= IDLE;
          end else begin
            x_cnt_reg <= x_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign b_wr      = run_reg && in_en && ((state_reg == IDLE) || (state_reg == LOAD));
  assign b_addr    = (state_reg == LOAD) ? load_cnt_reg : '0;
  assign upd_req   = (state_reg == ITER);
  assign row       = row_reg;
  assign x_rd      = (state_reg == OUT);
  assign x_addr    = x_cnt_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_gsim_ctrl.sv
// Directed bench for gsim_ctrl with N=16, N_ITER=2: load patterns, ack latency,
// spurious acks/in_en, back-to-back problems and mid-run reset.
module tb_gsim_ctrl;

  localparam int N      = 16;
  localparam int N_ITER = 2;
  localparam int AW     = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_en = 1'b0;
  logic          upd_ack = 1'b0;
  logic          b_wr, upd_req, x_rd, out_valid, busy;
  logic [AW-1:0] b_addr, row, x_addr;

  int total = 0;
  int fails = 0;
  int cyc_cnt = 0;
  int t0, t1;

  gsim_ctrl #(.N(N), .N_ITER(N_ITER), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .b_wr(b_wr), .b_addr(b_addr),
    .upd_req(upd_req), .row(row), .upd_ack(upd_ack), .x_rd(x_rd),
    .x_addr(x_addr), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_b_wr"}, 32'(b_wr), 0);
    chk({tag, "_upd_req"}, 32'(upd_req), 0);
    chk({tag, "_x_rd"}, 32'(x_rd), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_row"}, 32'(row), 0);
    chk({tag, "_b_addr"}, 32'(b_addr), 0);
    chk({tag, "_x_addr"}, 32'(x_addr), 0);
  endtask

  // Presents beats until N have been written; optional 1,1,0,0 gap pattern.
  task automatic load(input int first_beat, input bit gaps, input bit hold_after);
    int  beat = first_beat;
    int  cyc = 0;
    bit  en;
    while (beat < N && cyc < 200) begin
      en = gaps ? ((cyc % 4) < 2) : 1'b1;
      in_en = en;
      #1;
      chk("load_b_wr", 32'(b_wr), 32'(en));
      chk("load_upd_req", 32'(upd_req), 0);
      if (en) begin
        chk("load_b_addr", 32'(b_addr), 32'(beat));
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("load_beats", 32'(beat), 32'(N));
    in_en = hold_after;
  endtask

  // Walks sweeps/rows; returns early at the ITER cycle of index stop_at.
  task automatic sweeps(input int max_d, input bit spurious, input int stop_at);
    int d;
    for (int s = 0; s < N_ITER; s++) begin
      for (int r = 0; r < N; r++) begin
        upd_ack = spurious;
        #1;
        chk("iter_upd_req", 32'(upd_req), 1);
        chk("iter_row", 32'(row), 32'(r));
        chk("iter_b_wr", 32'(b_wr), 0);
        chk("iter_busy", 32'(busy), 1);
        chk("iter_x_rd", 32'(x_rd), 0);
        upd_ack = 1'b0;
        if (s * N + r == stop_at) return;
        @(negedge clk);
        d = (max_d <= 1) ? 1 : int'($urandom_range(1, max_d));
        for (int k = 1; k <= d; k++) begin
          upd_ack = (k == d);
          #1;
          chk("wait_upd_req", 32'(upd_req), 0);
          chk("wait_row", 32'(row), 32'(r));
          chk("wait_b_wr", 32'(b_wr), 0);
          @(negedge clk);
        end
        upd_ack = 1'b0;
      end
    end
  endtask

  task automatic out_phase(input bit spurious, input bit chain, input bit mark_end);
    for (int a = 0; a < N; a++) begin
      upd_ack = spurious && (a % 2 == 1);
      #1;
      chk("out_x_rd", 32'(x_rd), 1);
      chk("out_x_addr", 32'(x_addr), 32'(a));
      chk("out_valid", 32'(out_valid), 32'(a != 0));
      chk("out_upd_req", 32'(upd_req), 0);
      chk("out_b_wr", 32'(b_wr), 0);
      @(negedge clk);
    end
    upd_ack = 1'b0;
    in_en = chain;
    #1;
    if (mark_end) t1 = cyc_cnt;
    chk("end_x_rd", 32'(x_rd), 0);
    chk("end_out_valid", 32'(out_valid), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_b_wr", 32'(b_wr), 32'(chain));
    chk("end_b_addr", 32'(b_addr), 0);
    @(negedge clk);
    if (!chain) begin
      #1;
      chk("after_out_valid", 32'(out_valid), 0);
      chk("after_busy", 32'(busy), 0);
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset held with in_en high: everything must stay quiet.
    in_en = 1'b1;
    #1;
    all_zero("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("sync_first_edge_b_wr", 32'(b_wr), 0);
    @(negedge clk);

    // Problem 1: back-to-back load, ack after one cycle, end-to-end latency.
    t0 = cyc_cnt;
    load(0, 1'b0, 1'b0);
    sweeps(1, 1'b0, -1);
    out_phase(1'b0, 1'b0, 1'b1);
    chk("latency", 32'(t1 - t0), 32'(16 + 64 + 16));

    // Problem 2: gapped load, random ack latency, spurious acks, chained start.
    load(0, 1'b1, 1'b0);
    sweeps(7, 1'b1, -1);
    out_phase(1'b1, 1'b1, 1'b0);

    // Problem 3: in_en held high through ITER/WAIT/OUT.
    load(1, 1'b0, 1'b1);
    sweeps(1, 1'b0, -1);
    out_phase(1'b0, 1'b1, 1'b0);

    // Problem 4: abandoned by reset at sweep 1, row 7.
    load(1, 1'b0, 1'b0);
    sweeps(3, 1'b0, N + 7);
    in_en = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    all_zero("midrst");
    @(negedge clk);
    #1;
    all_zero("midrst_hold");
    @(negedge clk);
    reset = 1'b1;
    in_en = 1'b0;
    #1;
    all_zero("midrst_release");
    @(negedge clk);

    // Problem 5: normal run after the abandoned one.
    load(0, 1'b0, 1'b0);
    sweeps(5, 1'b1, -1);
    out_phase(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
